// File: rtl/snap_tx_capture_ctrl_pkg.sv
// Shared types and bit positions for the TX snapshot capture controller.
// Imported by the controller and its bench.
package snap_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DONE
    } state_t;

    localparam int CTRL_ARM       = 0;
    localparam int CTRL_TRIG_MODE = 1;
    localparam int CTRL_WE_GATE   = 2;

    localparam int ST_DONE = 31;
    localparam int ST_BUSY = 30;
    localparam int ST_WRAP = 29;

endpackage

// File: rtl/snap_tx_capture_ctrl_if.sv
// Tap-side inputs, BRAM write port and status word of the snapshot controller.
// The slave modport is the controller; the master modport is its environment.
interface snap_tx_capture_ctrl_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 64
);
    logic [31:0]       ctrl;
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              trig;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_data;
    logic [31:0]       status;

    modport slave (
        input  ctrl,
        input  din,
        input  din_valid,
        input  trig,
        output bram_we,
        output bram_addr,
        output bram_data,
        output status
    );

    modport master (
        output ctrl,
        output din,
        output din_valid,
        output trig,
        input  bram_we,
        input  bram_addr,
        input  bram_data,
        input  status
    );
endinterface

// File: rtl/snap_tx_capture_ctrl_edge_det.sv
// Rising-edge detector: registers the level, flags level & ~previous.
module snap_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);
    logic level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    assign rise = level & ~level_d;
endmodule

// File: rtl/snap_tx_capture_ctrl.sv
// TX snapshot capture sequencer: arm, optional trigger, BRAM writes, stop when full.
// Define SNAP_CIRC_EN for pre-trigger circular capture with a wrap flag in status.
module snap_tx_capture_ctrl #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 64
) (
    input  logic                  user_clk,
    input  logic                  user_rst_n,
    snap_tx_capture_ctrl_if.slave bus
);
    import snap_ctrl_pkg::*;

    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

    state_t          state;
    logic [ADDR_W:0] count;
    logic [ADDR_W:0] cnt_nxt;
    logic            arm_rise;
    logic            trig_mode;
    logic            we_gate;
    logic            qual;
    logic [31:0]     status_nxt;
    logic            unused_ctrl;
`ifdef SNAP_CIRC_EN
    localparam logic [ADDR_W-1:0] HALF = {1'b1, {(ADDR_W-1){1'b0}}};

    logic              circ_run;
    logic              wrapped;
    logic [ADDR_W-1:0] trig_addr;
    logic [ADDR_W-1:0] ptr_nxt;
    logic [ADDR_W-1:0] stop_ptr;
    logic              ptr_last;
`endif

    snap_edge_det u_arm (
        .clk   (user_clk),
        .rst_n (user_rst_n),
        .level (bus.ctrl[CTRL_ARM]),
        .rise  (arm_rise)
    );

    assign trig_mode   = bus.ctrl[CTRL_TRIG_MODE];
    assign we_gate     = bus.ctrl[CTRL_WE_GATE];
    assign qual        = ~we_gate | bus.din_valid;
    assign cnt_nxt     = count + 1'b1;
    assign unused_ctrl = ^bus.ctrl[31:3];
`ifdef SNAP_CIRC_EN
    assign ptr_nxt  = cnt_nxt[ADDR_W-1:0];
    assign stop_ptr = trig_addr + HALF;
    assign ptr_last = &count[ADDR_W-1:0];
`endif

    always_comb begin
        status_nxt = '0;
        status_nxt[ST_DONE] = (state == DONE);
        status_nxt[ST_BUSY] = (state == ARMED) || (state == CAPTURE);
`ifdef SNAP_CIRC_EN
        status_nxt[ST_WRAP] = wrapped;
`endif
        status_nxt[ADDR_W:0] = count;
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state         <= IDLE;
            count         <= '0;
            bus.bram_we   <= 1'b0;
            bus.bram_addr <= '0;
            bus.bram_data <= '0;
            bus.status    <= '0;
`ifdef SNAP_CIRC_EN
            circ_run  <= 1'b0;
            wrapped   <= 1'b0;
            trig_addr <= '0;
`endif
        end else begin
            bus.bram_we <= 1'b0;
            bus.status  <= status_nxt;
            // A new arm edge wins over any write due this cycle.
            if (arm_rise) begin
                count <= '0;
                state <= trig_mode ? ARMED : CAPTURE;
`ifdef SNAP_CIRC_EN
                circ_run <= 1'b0;
                wrapped  <= 1'b0;
`endif
            end else begin
                unique case (state)
                    ARMED: begin
`ifdef SNAP_CIRC_EN
                        if (qual) begin
                            bus.bram_we   <= 1'b1;
                            bus.bram_addr <= count[ADDR_W-1:0];
                            bus.bram_data <= bus.din;
                            count         <= {1'b0, ptr_nxt};
                            if (ptr_last) wrapped <= 1'b1;
                        end
                        if (bus.trig) begin
                            trig_addr <= count[ADDR_W-1:0];
                            circ_run  <= 1'b1;
                            state     <= CAPTURE;
                        end
`else
                        if (bus.trig) begin
                            state <= CAPTURE;
                            if (qual) begin
                                bus.bram_we   <= 1'b1;
                                bus.bram_addr <= count[ADDR_W-1:0];
                                bus.bram_data <= bus.din;
                                count         <= cnt_nxt;
                            end
                        end
`endif
                    end
                    CAPTURE: begin
                        if (qual) begin
                            bus.bram_we   <= 1'b1;
                            bus.bram_addr <= count[ADDR_W-1:0];
                            bus.bram_data <= bus.din;
`ifdef SNAP_CIRC_EN
                            if (circ_run) begin
                                count <= {1'b0, ptr_nxt};
                                if (ptr_last) wrapped <= 1'b1;
                                if (ptr_nxt == stop_ptr) state <= DONE;
                            end else begin
                                count <= cnt_nxt;
                                if (cnt_nxt == FULL) state <= DONE;
                            end
`else
                            count <= cnt_nxt;
                            if (cnt_nxt == FULL) state <= DONE;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/snap_tx_capture_ctrl.md
Name: snap_tx_capture_ctrl

Overview:
- Sequences one snapshot capture of the 10GbE TX stream into a snapshot BRAM: arm, optional trigger, write-address generation, stop when full.
- Publishes a 32-bit status/address word. That word drives user_data_in of the software-readable TX-snapshot address register. The software control word arrives from a ppc2simulink register.
- Sits in the user_clk domain between the TX datapath tap and the snap BRAM and registers.

Parameters:
- ADDR_W, 11, BRAM address width; depth = 2**ADDR_W words.
- DATA_W, 64, captured data width.

Ports:
- user_clk  in  1  capture clock, rising edge.
- user_rst_n  in  1  asynchronous active-low reset.
- ctrl  in  32  software control: bit0 arm (edge-detected), bit1 trig_mode (0 = start on arm, 1 = wait for trig), bit2 we_gate (1 = write only when din_valid).
- din  in  DATA_W  TX data tap.
- din_valid  in  1  tap qualifier.
- trig  in  1  capture trigger, level-sampled.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  ADDR_W  BRAM write address.
- bram_data  out  DATA_W  BRAM write data.
- status  out  32  {done, busy, 30-ADDR_W-1 zeros, count[ADDR_W:0]}; feeds the snapshot address register.

Behaviour:
- Reset values: all outputs 0; state IDLE; count 0; arm_d 0.
- Arm edge: arm_rise = ctrl[0] & ~arm_d. arm_d is registered every cycle.
- States:
  - IDLE: on arm_rise, clear count and done. Go to CAPTURE if trig_mode=0, else ARMED.
  - ARMED: on trig=1, go to CAPTURE. The trigger-cycle sample is the first sample written.
  - CAPTURE: a write qualifies when we_gate=0, or when we_gate=1 and din_valid=1.
  - DONE: done=1, busy=0. Hold until the next arm_rise, which restarts as from IDLE.
- CAPTURE write timing:
  - Each qualifying cycle registers bram_we=1, bram_addr=count[ADDR_W-1:0] and bram_data=din, then increments count.
  - Latency from input to BRAM port is exactly 1 cycle. bram_we is 0 in all other cycles.
- CAPTURE stop: when count reaches 2**ADDR_W after an increment, go to DONE. No further writes; the address never wraps.
- busy=1 in ARMED and CAPTURE.
- status is registered and updates the cycle after the state or count changes. count saturates at 2**ADDR_W, so count[ADDR_W] set means full.
- arm_rise while ARMED or CAPTURE restarts the capture: count cleared, state re-entered per trig_mode. Any in-flight write of that cycle is suppressed.
- arm held high does not retrigger; it must fall, then rise.
- Async reset mid-capture returns to IDLE immediately. Partial BRAM contents are not cleared.

Optional Feature:
- Macro SNAP_CIRC_EN: pre-trigger circular capture.
- With the macro:
  - ARMED also writes qualifying samples, with bram_addr wrapping modulo 2**ADDR_W.
  - On trig, record trig_addr and write exactly 2**(ADDR_W-1) further samples, then go to DONE.
  - status[ADDR_W:0] reports the last written address + 1 (mod depth) as the read start point.
  - status bit 29 = wrapped, set if at least one wrap occurred before the stop.
- Without the macro: ARMED writes nothing, status bit 29 is constantly 0, and no wrap logic is synthesised.

Decomposition:
- Package snap_ctrl_pkg:
  - state enum {IDLE, ARMED, CAPTURE, DONE};
  - ctrl bit-index constants CTRL_ARM=0, CTRL_TRIG_MODE=1, CTRL_WE_GATE=2;
  - status bit constants ST_DONE=31, ST_BUSY=30, ST_WRAP=29.
- One sub-module, snap_edge_det (registered rising-edge detector), reused for arm.

Test Plan:
- Immediate mode, ADDR_W=4, we_gate=0:
  - stimulus: ctrl 0→1; din increments each cycle.
  - required: 16 writes at addr 0..15 carrying the 16 consecutive din values; status = 0x80000010; bram_we=0 afterwards.
- Triggered mode:
  - stimulus: ctrl=0x3; trig pulses 20 cycles later.
  - required: busy=1 and no writes before trig; first write has data = din at the trigger cycle and addr 0.
- Gated writes:
  - stimulus: ctrl=0x5; din_valid toggles 1,0,1,0.
  - required: writes only on valid cycles with addresses contiguous; capture completes after 16 valid samples.
- Re-arm mid-capture:
  - stimulus: arm falls and rises again at count=7.
  - required: count clears to 0 and the next write uses addr 0; done stays 0.
- Async reset mid-capture:
  - stimulus: assert user_rst_n low for a non-edge-aligned time.
  - required: all outputs 0 immediately; IDLE on release; no write until the next arm_rise.
- SNAP_CIRC_EN, ADDR_W=4:
  - stimulus: arm; 30 samples; then trig.
  - required: exactly 8 post-trigger writes, then DONE; wrap bit set; status address = (last addr + 1) mod 16.
